// File: rtl/truth_table_capture.sv
// truth_table_capture: sweeps every input pattern into a combinational function and checks the captured truth table against a golden one
module truth_table_capture #(
  parameter int N_IN   = 5,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2**N_IN-1:0]   expected,
  input  logic                 f_in,
  output logic [N_IN-1:0]      stim,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2**N_IN-1:0]   tbl,
  output logic [N_IN:0]        mism_cnt,
  output logic [N_IN-1:0]      first_mism
);
  localparam int CW = SETTLE > 1 ? $clog2(SETTLE) : 1;
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic [2**N_IN-1:0] exp_q;
  logic samp, last, miss;
  logic [N_IN:0] mism_nxt;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  // next state, sample strobe and status outputs
  always_comb begin
    samp = state == RUN && cnt == CW'(SETTLE - 1);
    last = stim == N_IN'(2**N_IN - 1);
    miss = f_in != exp_q[stim];
    mism_nxt = mism_cnt + (N_IN + 1)'(miss);
    state_nxt = state == IDLE ? (start ? RUN : IDLE) :
                state == RUN  ? (samp && last ? FIN : RUN) : IDLE;
    busy = state == RUN;
    done = state == FIN;
  end
  // sweep datapath: pattern/settle counters, table capture and mismatch bookkeeping
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      exp_q <= '0;
      tbl <= '0;
      mism_cnt <= '0;
      first_mism <= '0;
      pass <= 1'b0;
      stim <= '0;
      cnt <= '0;
    end else if (state == IDLE && start) begin
      exp_q <= expected;
      tbl <= '0;
      mism_cnt <= '0;
      first_mism <= '0;
      pass <= 1'b0;
      stim <= '0;
      cnt <= '0;
    end else if (state == RUN) begin
      if (samp) begin
        tbl[stim] <= f_in;
        mism_cnt <= mism_nxt;
        if (miss && mism_cnt == '0) first_mism <= stim;
        if (last) begin
          stim <= '0;
          pass <= mism_nxt == '0;
        end else stim <= stim + 1'b1;
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
endmodule
